// File: rtl/color_entry_buffer_if.sv
// Keypad entry bus: strobes and ack toward the buffer, live/committed words back.
interface color_entry_buffer_if #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4
);
  localparam int WORD_W = NUM_DIGITS * DIGIT_W;
  localparam int CW     = $clog2(NUM_DIGITS + 1);

  logic              button_pressed;
  logic [DIGIT_W-1:0] button;
  logic              backspace;
  logic              clear;
  logic              ack;
  logic [WORD_W-1:0] final_color;
  logic [CW-1:0]     count;
  logic              done;
  logic [WORD_W-1:0] committed_color;
  logic              commit_pulse;

  modport master (
    output button_pressed, button, backspace, clear, ack,
    input  final_color, count, done, committed_color, commit_pulse
  );

  modport slave (
    input  button_pressed, button, backspace, clear, ack,
    output final_color, count, done, committed_color, commit_pulse
  );
endinterface

// File: rtl/color_entry_buffer.sv
// Digit-entry accumulator, MSD first; 1-cycle update latency, full word held until ack.
// ENTRY_TIMEOUT_EN adds an idle counter that discards stale partial entries.
module color_entry_buffer #(
  parameter int NUM_DIGITS     = 6,
  parameter int DIGIT_W        = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  color_entry_buffer_if.slave bus
);
  localparam int WORD_W = NUM_DIGITS * DIGIT_W;
  localparam int CW     = $clog2(NUM_DIGITS + 1);

  typedef enum logic {ENTRY, FULL} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] word, word_nxt;
  logic [WORD_W-1:0] committed, committed_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              done_q;
  logic              pulse, pulse_nxt;
  logic              expire;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle;
  logic          running;
  logic          kick;

  assign running = (state == ENTRY) && (cnt != '0);
  assign kick    = bus.button_pressed | bus.backspace | bus.clear;
  assign expire  = running && !kick && (idle == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        idle <= '0;
    else if (kick || !running || expire) idle <= '0;
    else                               idle <= idle + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    word_nxt      = word;
    cnt_nxt       = cnt;
    committed_nxt = committed;
    pulse_nxt     = 1'b0;

    if (bus.clear || expire) begin
      word_nxt  = '0;
      cnt_nxt   = '0;
      state_nxt = ENTRY;
    end else if (bus.backspace) begin
      if (cnt != '0) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          if (k == int'(cnt) - 1) word_nxt[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] = '0;
        cnt_nxt   = cnt - 1'b1;
        state_nxt = ENTRY;
      end
    end else if (bus.ack && state == FULL) begin
      committed_nxt = word;
      pulse_nxt     = 1'b1;
      word_nxt      = '0;
      cnt_nxt       = '0;
      state_nxt     = ENTRY;
    end else if (bus.button_pressed && state == ENTRY) begin
      // Slot index equals the current count; constant part-selects after unrolling.
      for (int k = 0; k < NUM_DIGITS; k++)
        if (k == int'(cnt)) word_nxt[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] = bus.button;
      cnt_nxt = cnt + 1'b1;
      if (cnt == CW'(NUM_DIGITS - 1)) state_nxt = FULL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ENTRY;
      word      <= '0;
      cnt       <= '0;
      committed <= '0;
      pulse     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      word      <= word_nxt;
      cnt       <= cnt_nxt;
      committed <= committed_nxt;
      pulse     <= pulse_nxt;
      done_q    <= (state_nxt == FULL);
    end
  end

  assign bus.final_color     = word;
  assign bus.count           = cnt;
  assign bus.done            = done_q;
  assign bus.committed_color = committed;
  assign bus.commit_pulse    = pulse;
endmodule

// File: tb/tb_color_entry_buffer.sv
// Scoreboard bench: a digit-array reference model predicts each cycle's outputs.
module tb_color_entry_buffer;
  localparam int N = 6;
  localparam int W = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  color_entry_buffer_if #(.NUM_DIGITS(N), .DIGIT_W(W)) bus();

  color_entry_buffer #(.NUM_DIGITS(N), .DIGIT_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [23:0] word;
    logic [2:0]  cnt;
    logic        done;
    logic [23:0] comm;
    logic        pulse;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  logic [3:0]  digs[N];
  int          m_cnt;
  int          m_idle;
  logic [23:0] m_comm;
  logic        m_pulse;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [23:0] m_word();
    logic [23:0] w = '0;
    for (int k = 0; k < m_cnt; k++) w = w | ({20'h0, digs[k]} << ((N - 1 - k) * W));
    return w;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) digs[k] = 4'h0;
    m_cnt = 0; m_idle = 0; m_comm = '0; m_pulse = 1'b0;
  endtask

  task automatic m_clear();
    for (int k = 0; k < N; k++) digs[k] = 4'h0;
    m_cnt = 0;
  endtask

  task automatic model_step(bit bp, logic [3:0] btn, bit bs, bit clr, bit ak);
    bit tmo = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    if (bp || bs || clr || m_cnt == 0 || m_cnt == N) m_idle = 0;
    else if (m_idle == T - 1) begin tmo = 1'b1; m_idle = 0; end
    else m_idle++;
`endif
    m_pulse = 1'b0;
    if (clr || tmo) m_clear();
    else if (bs) begin
      if (m_cnt > 0) begin m_cnt--; digs[m_cnt] = 4'h0; end
    end else if (ak && m_cnt == N) begin
      m_comm = m_word(); m_pulse = 1'b1; m_clear();
    end else if (bp && m_cnt < N) begin
      digs[m_cnt] = btn; m_cnt++;
    end
  endtask

  task automatic compare_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, no expected value", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".word"},  32'(bus.final_color),     32'(e.word));
      check({tag, ".cnt"},   32'(bus.count),           32'(e.cnt));
      check({tag, ".done"},  32'(bus.done),            32'(e.done));
      check({tag, ".comm"},  32'(bus.committed_color), 32'(e.comm));
      check({tag, ".pulse"}, 32'(bus.commit_pulse),    32'(e.pulse));
    end
  endtask

  task automatic step(bit bp, logic [3:0] btn, bit bs, bit clr, bit ak, string tag);
    exp_t e;
    @(negedge clk);
    bus.button_pressed = bp; bus.button = btn;
    bus.backspace = bs; bus.clear = clr; bus.ack = ak;
    model_step(bp, btn, bs, clr, ak);
    e.word = m_word(); e.cnt = 3'(m_cnt); e.done = (m_cnt == N);
    e.comm = m_comm; e.pulse = m_pulse;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.button_pressed = 1'b0; bus.backspace = 1'b0; bus.clear = 1'b0; bus.ack = 1'b0;
    compare_out(tag);
  endtask

  task automatic digit(logic [3:0] d, string tag);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(string tag);
    step(1'b0, 4'hf, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic check_zero(string tag);
    check({tag, ".word"},  32'(bus.final_color),     32'h0);
    check({tag, ".cnt"},   32'(bus.count),           32'h0);
    check({tag, ".done"},  32'(bus.done),            32'h0);
    check({tag, ".comm"},  32'(bus.committed_color), 32'h0);
    check({tag, ".pulse"}, 32'(bus.commit_pulse),    32'h0);
  endtask

  task automatic fill(logic [23:0] v, string tag);
    logic [23:0] t = v;
    for (int k = 0; k < N; k++) digit(t[23 - 4*k -: 4], tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.button_pressed = 1'b0; bus.button = 4'h0;
    bus.backspace = 1'b0; bus.clear = 1'b0; bus.ack = 1'b0;
    m_reset();
    #12;
    check_zero("rst");
    @(negedge clk) reset = 1'b1;

    // Entry of c5a0d8 with a non-strobed button change in the middle.
    digit(4'hc, "d0"); digit(4'h5, "d1"); digit(4'ha, "d2");
    idle("nostrobe");
    digit(4'h0, "d3"); digit(4'hd, "d4"); digit(4'h8, "d5");
    check("full.word", 32'(bus.final_color), 32'hc5a0d8);
    check("full.done", 32'(bus.done), 32'h1);

    digit(4'h3, "full_ignore");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "ack");
    check("ack.comm", 32'(bus.committed_color), 32'hc5a0d8);
    idle("pulse_drop");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "ack_entry");

    // Backspace, including underflow at count 0.
    digit(4'hc, "b0"); digit(4'h5, "b1"); digit(4'ha, "b2");
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "bs1");
    check("bs1.word", 32'(bus.final_color), 32'hc50000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "bsx");
    digit(4'h7, "after_bs");
    check("after_bs.word", 32'(bus.final_color), 32'h700000);

    // Priority: clear over ack, backspace over ack, backspace over button.
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "clr");
    fill(24'hc5a0d8, "f1");
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, "clr_ack");
    fill(24'hc5a0d8, "f2");
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, "bs_ack");
    check("bs_ack.word", 32'(bus.final_color), 32'hc5a0d0);
    step(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, "bs_btn");
    digit(4'hd, "refill4"); digit(4'h8, "refill5");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "ack2");
    idle("ack2_idle");

    // Asynchronous reset mid-entry, between clock edges.
    fill(24'h123456, "f3");
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "ack3");
    check("ack3.comm", 32'(bus.committed_color), 32'h123456);
    digit(4'h1, "m0"); digit(4'h2, "m1"); digit(4'h3, "m2");
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    m_reset();
    @(negedge clk) reset = 1'b1;

    // Idle behaviour of a partial entry and of a full one.
    digit(4'hc, "t0");
    for (int i = 0; i < T; i++) idle("tidle");
`ifdef ENTRY_TIMEOUT_EN
    check("tmo.cnt", 32'(bus.count), 32'h0);
`else
    check("hold.cnt", 32'(bus.count), 32'h1);
`endif
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "clr2");
    fill(24'hc5a0d8, "f4");
    for (int i = 0; i < 20; i++) idle("fidle");
    check("full_hold.done", 32'(bus.done), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
